// File: rtl/bias_add_pkg.sv
// bias_add_pkg: shared constants and helpers for the bias-add stage.
//   LANES   - parallel output lanes per beat
//   DW      - signed width of each accumulator, bias and output lane
//   SAT_MAX - most positive DW-bit two's-complement value
//   SAT_MIN - most negative DW-bit two's-complement value
//   lane_slice() - extract lane i from a packed LANES*DW word
package bias_add_pkg;

  localparam int unsigned LANES = 16;
  localparam int unsigned DW    = 32;

  localparam logic [DW-1:0] SAT_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] SAT_MIN = {1'b1, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] lane_slice(input logic [LANES*DW-1:0] word,
                                               input int unsigned         idx);
    return word[idx*DW +: DW];
  endfunction

endpackage

// File: rtl/bias_lane_sat.sv
// bias_lane_sat: single-lane combinational signed add with saturation and
// optional ReLU.
//   acc_i     - signed accumulator lane
//   bias_i    - signed bias lane
//   relu_en_i - force negative results to zero
//   res_o     - saturated (and optionally rectified) sum
module bias_lane_sat
  import bias_add_pkg::*;
#(
  parameter int unsigned LW = DW
) (
  input  logic [LW-1:0] acc_i,
  input  logic [LW-1:0] bias_i,
  input  logic          relu_en_i,
  output logic [LW-1:0] res_o
);

  localparam logic [LW-1:0] L_MAX = {1'b0, {(LW-1){1'b1}}};
  localparam logic [LW-1:0] L_MIN = {1'b1, {(LW-1){1'b0}}};

  logic [LW:0]   sum;
  logic [LW-1:0] sat;

  always_comb begin
    sum = {acc_i[LW-1], acc_i} + {bias_i[LW-1], bias_i};
    // The two top bits of the sign-extended sum disagree only on overflow;
    // bit LW carries the true sign.
    unique case (sum[LW:LW-1])
      2'b01:   sat = L_MAX;
      2'b10:   sat = L_MIN;
      default: sat = sum[LW-1:0];
    endcase
    res_o = (relu_en_i && sat[LW-1]) ? '0 : sat;
  end

endmodule

// File: rtl/bias_add.sv
// bias_add: pops one bias word per output-channel group from the bias FIFO
// and adds it lane-wise to every accumulator beat of that group.
//   clk_200M     - system clock
//   rst_n        - asynchronous active-low reset
//   fifo_empty   - bias FIFO empty flag
//   fifo_rd_en   - bias FIFO pop (data valid one cycle later)
//   fifo_rd_data - bias word, lane i at [i*DW +: DW]
//   acc_in_vld   - accumulator beat valid
//   acc_in_last  - last beat of the current channel group
//   acc_in       - signed accumulator lanes
//   acc_in_rdy   - beat accepted when acc_in_vld && acc_in_rdy
//   relu_en      - clamp negative results to zero, per beat
//   out_vld      - result valid, one cycle after acceptance
//   out_data     - biased, saturated result (zero when out_vld=0)
//   grp_cnt      - completed channel groups, wraps at 16 bits
//   err_underrun - sticky: a beat was offered with no bias available
module bias_add
  import bias_add_pkg::*;
(
  input  logic                clk_200M,
  input  logic                rst_n,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [LANES*DW-1:0] fifo_rd_data,
  input  logic                acc_in_vld,
  input  logic                acc_in_last,
  input  logic [LANES*DW-1:0] acc_in,
  output logic                acc_in_rdy,
  input  logic                relu_en,
  output logic                out_vld,
  output logic [LANES*DW-1:0] out_data,
  output logic [15:0]         grp_cnt,
  output logic                err_underrun
);

  logic [LANES*DW-1:0] cur_q, cur_d;
  logic [LANES*DW-1:0] nxt_q, nxt_d;
  logic                cur_vld_q, cur_vld_d;
  logic                nxt_vld_q, nxt_vld_d;
  logic                rd_pend_q, rd_pend_d;
  logic [15:0]         grp_cnt_q, grp_cnt_d;
  logic                err_q, err_d;
  logic                out_vld_q, out_vld_d;
  logic [LANES*DW-1:0] out_data_q, out_data_d;
  logic [LANES*DW-1:0] lane_res;

  logic accept;
  logic grp_sw;
  logic capture;

  assign accept     = acc_in_vld && cur_vld_q;
  assign grp_sw     = accept && acc_in_last;
  assign capture    = rd_pend_q;
  assign fifo_rd_en = !fifo_empty && !nxt_vld_q && !rd_pend_q;
  assign acc_in_rdy = cur_vld_q;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    bias_lane_sat #(.LW(DW)) u_lane (
      .acc_i     (acc_in[g*DW +: DW]),
      .bias_i    (cur_q[g*DW +: DW]),
      .relu_en_i (relu_en),
      .res_o     (lane_res[g*DW +: DW])
    );
  end

  always_comb begin
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    cur_vld_d  = cur_vld_q;
    nxt_vld_d  = nxt_vld_q;
    rd_pend_d  = fifo_rd_en;
    grp_cnt_d  = grp_cnt_q;
    err_d      = err_q | (acc_in_vld & ~cur_vld_q);
    out_vld_d  = accept;
    out_data_d = accept ? lane_res : '0;

    if (grp_sw) begin
      grp_cnt_d = grp_cnt_q + 16'd1;
    end

    // Switch and refill share one path: whenever cur is free after this
    // edge, the prefetched word wins and any landing capture backfills nxt.
    if (grp_sw || !cur_vld_q) begin
      if (nxt_vld_q) begin
        cur_d     = nxt_q;
        cur_vld_d = 1'b1;
        nxt_vld_d = 1'b0;
        if (capture) begin
          nxt_d     = fifo_rd_data;
          nxt_vld_d = 1'b1;
        end
      end else if (capture) begin
        cur_d     = fifo_rd_data;
        cur_vld_d = 1'b1;
      end else begin
        cur_vld_d = 1'b0;
      end
    end else if (capture) begin
      nxt_d     = fifo_rd_data;
      nxt_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      nxt_q      <= '0;
      cur_vld_q  <= 1'b0;
      nxt_vld_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      grp_cnt_q  <= '0;
      err_q      <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
    end else begin
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
      cur_vld_q  <= cur_vld_d;
      nxt_vld_q  <= nxt_vld_d;
      rd_pend_q  <= rd_pend_d;
      grp_cnt_q  <= grp_cnt_d;
      err_q      <= err_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign out_vld      = out_vld_q;
  assign out_data     = out_data_q;
  assign grp_cnt      = grp_cnt_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_bias_add.sv
// tb_bias_add: directed, table-driven bench for bias_add with a small
// behavioural bias FIFO (pop data registered one cycle after fifo_rd_en).
module tb_bias_add;
  import bias_add_pkg::*;

  localparam int unsigned W = LANES * DW;

  logic          clk_200M;
  logic          rst_n;
  logic          fifo_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_rd_data;
  logic          acc_in_vld;
  logic          acc_in_last;
  logic [W-1:0]  acc_in;
  logic          acc_in_rdy;
  logic          relu_en;
  logic          out_vld;
  logic [W-1:0]  out_data;
  logic [15:0]   grp_cnt;
  logic          err_underrun;

  bias_add dut (
    .clk_200M     (clk_200M),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .acc_in_vld   (acc_in_vld),
    .acc_in_last  (acc_in_last),
    .acc_in       (acc_in),
    .acc_in_rdy   (acc_in_rdy),
    .relu_en      (relu_en),
    .out_vld      (out_vld),
    .out_data     (out_data),
    .grp_cnt      (grp_cnt),
    .err_underrun (err_underrun)
  );

  initial clk_200M = 1'b0;
  always #5 clk_200M = ~clk_200M;

  // Bias FIFO model, reset by the same rst_n as the DUT.
  logic [W-1:0] fq[$];
  logic         push_req;
  logic [W-1:0] push_word;
  logic [W-1:0] pop_w;
  int unsigned  pop_cnt;

  always @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_rd_data <= '0;
      fifo_empty   <= 1'b1;
      pop_cnt      <= 0;
    end else begin
      if (fifo_rd_en && fq.size() > 0) begin
        pop_w = fq.pop_front();
        fifo_rd_data <= pop_w;
        pop_cnt      <= pop_cnt + 1;
      end
      if (push_req) fq.push_back(push_word);
      fifo_empty <= (fq.size() == 0);
    end
  end

  int unsigned pass_cnt;
  int unsigned total_cnt;
  logic [15:0] exp_grp;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [W-1:0] mk(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LANES; i++) r[i*DW +: DW] = (i % 2 == 0) ? a : b;
    return r;
  endfunction

  // Called at a negedge; returns at a negedge.
  task automatic push(input logic [W-1:0] w);
    push_req  = 1'b1;
    push_word = w;
    @(negedge clk_200M);
    push_req  = 1'b0;
  endtask

  task automatic wait_rdy(input string nm);
    int unsigned n;
    n = 0;
    while (!acc_in_rdy && n < 20) begin
      @(negedge clk_200M);
      n++;
    end
    chk(nm, W'(acc_in_rdy), W'(1'b1));
  endtask

  typedef struct {
    logic [DW-1:0] acc_a;
    logic [DW-1:0] bias_a;
    logic [DW-1:0] acc_b;
    logic [DW-1:0] bias_b;
    logic          relu;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int unsigned p0;

    tbl[0] = '{32'd10,        32'd5,        32'hFFFFFFEC, 32'd4,        1'b0, 32'd15,        32'hFFFFFFF0};
    tbl[1] = '{32'h7FFFFFF0,  32'h20,       32'h80000005, 32'hFFFFFFF0, 1'b0, 32'h7FFFFFFF,  32'h80000000};
    tbl[2] = '{32'hFFFFFFF9,  32'd3,        32'h7FFFFFF0, 32'h20,       1'b1, 32'h0,         32'h7FFFFFFF};
    tbl[3] = '{32'hFFFFFFF9,  32'd3,        32'h80000005, 32'hFFFFFFF0, 1'b0, 32'hFFFFFFFC,  32'h80000000};
    tbl[4] = '{32'd100,       32'hFFFFFFCE, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h32,        32'h0};
    tbl[5] = '{32'h7FFFFFFE,  32'd1,        32'h80000001, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF,  32'h80000000};
    tbl[6] = '{32'h0,         32'h0,        32'hFFFFFFFF, 32'd1,        1'b0, 32'h0,         32'h0};

    pass_cnt    = 0;
    total_cnt   = 0;
    exp_grp     = '0;
    push_req    = 1'b0;
    push_word   = '0;
    acc_in_vld  = 1'b0;
    acc_in_last = 1'b0;
    acc_in      = '0;
    relu_en     = 1'b0;
    rst_n       = 1'b0;

    // Reset state
    repeat (2) @(negedge clk_200M);
    chk("rst_out_vld",  W'(out_vld),      '0);
    chk("rst_out_data", out_data,         '0);
    chk("rst_grp_cnt",  W'(grp_cnt),      '0);
    chk("rst_err",      W'(err_underrun), '0);
    chk("rst_rdy",      W'(acc_in_rdy),   '0);
    chk("rst_rd_en",    W'(fifo_rd_en),   '0);
    rst_n = 1'b1;
    @(negedge clk_200M);

    // Basic add: one bias word of 5s, three beats of 10s
    p0 = pop_cnt;
    push(mk(32'd5, 32'd5));
    wait_rdy("basic_rdy");
    for (int unsigned b = 0; b < 3; b++) begin
      acc_in_vld  = 1'b1;
      acc_in      = mk(32'd10, 32'd10);
      acc_in_last = (b == 2);
      @(negedge clk_200M);
      chk("basic_vld",  W'(out_vld), W'(1'b1));
      chk("basic_data", out_data,    mk(32'd15, 32'd15));
    end
    acc_in_vld  = 1'b0;
    acc_in_last = 1'b0;
    exp_grp++;
    chk("basic_rdy_drop", W'(acc_in_rdy), '0);
    chk("basic_grp",      W'(grp_cnt),    W'(exp_grp));
    @(negedge clk_200M);
    chk("basic_out_idle", W'(out_vld),         '0);
    chk("basic_pops",     W'(pop_cnt - p0),    W'(1));

    // Table-driven single-beat groups
    for (int unsigned v = 0; v < 7; v++) begin
      push(mk(tbl[v].bias_a, tbl[v].bias_b));
      wait_rdy("tbl_rdy");
      acc_in_vld  = 1'b1;
      acc_in_last = 1'b1;
      acc_in      = mk(tbl[v].acc_a, tbl[v].acc_b);
      relu_en     = tbl[v].relu;
      @(negedge clk_200M);
      acc_in_vld  = 1'b0;
      acc_in_last = 1'b0;
      relu_en     = 1'b0;
      exp_grp++;
      chk($sformatf("tbl%0d_vld", v),  W'(out_vld), W'(1'b1));
      chk($sformatf("tbl%0d_data", v), out_data,    mk(tbl[v].exp_a, tbl[v].exp_b));
    end
    chk("tbl_grp", W'(grp_cnt), W'(exp_grp));

    // Back-to-back single-beat groups, zero-bubble switch
    push(mk(32'd1, 32'd1));
    push(mk(32'd2, 32'd2));
    wait_rdy("b2b_rdy");
    repeat (4) @(negedge clk_200M);
    acc_in_vld  = 1'b1;
    acc_in_last = 1'b1;
    acc_in      = mk(32'd100, 32'd100);
    @(negedge clk_200M);
    chk("b2b_vld0",  W'(out_vld),    W'(1'b1));
    chk("b2b_data0", out_data,       mk(32'd101, 32'd101));
    chk("b2b_rdy",   W'(acc_in_rdy), W'(1'b1));
    acc_in = mk(32'd200, 32'd200);
    @(negedge clk_200M);
    acc_in_vld  = 1'b0;
    acc_in_last = 1'b0;
    exp_grp     = exp_grp + 16'd2;
    chk("b2b_vld1",  W'(out_vld),    W'(1'b1));
    chk("b2b_data1", out_data,       mk(32'd202, 32'd202));
    chk("b2b_grp",   W'(grp_cnt),    W'(exp_grp));
    chk("b2b_drop",  W'(acc_in_rdy), '0);
    chk("b2b_noerr", W'(err_underrun), '0);

    // Underrun: beat offered with empty FIFO, then the bias arrives
    acc_in_vld  = 1'b1;
    acc_in_last = 1'b1;
    acc_in      = mk(32'd50, 32'd50);
    repeat (2) begin
      @(negedge clk_200M);
      chk("ur_rdy_low", W'(acc_in_rdy),   '0);
      chk("ur_err",     W'(err_underrun), W'(1'b1));
    end
    push(mk(32'd7, 32'd7));
    chk("ur_rdy_p0", W'(acc_in_rdy), '0);
    @(negedge clk_200M);
    chk("ur_rdy_p1", W'(acc_in_rdy), '0);
    @(negedge clk_200M);
    chk("ur_rdy_p2",   W'(acc_in_rdy), W'(1'b1));
    chk("ur_no_out",   W'(out_vld),    '0);
    @(negedge clk_200M);
    acc_in_vld  = 1'b0;
    acc_in_last = 1'b0;
    exp_grp++;
    chk("ur_vld",      W'(out_vld),      W'(1'b1));
    chk("ur_data",     out_data,         mk(32'd57, 32'd57));
    chk("ur_err_hold", W'(err_underrun), W'(1'b1));
    chk("ur_grp",      W'(grp_cnt),      W'(exp_grp));

    // Reset mid-group: one of four beats, then asynchronous reset
    push(mk(32'd3, 32'd3));
    wait_rdy("mid_rdy");
    acc_in_vld = 1'b1;
    acc_in     = mk(32'd20, 32'd20);
    @(negedge clk_200M);
    acc_in_vld = 1'b0;
    chk("mid_data", out_data, mk(32'd23, 32'd23));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vld",  W'(out_vld),      '0);
    chk("mid_rst_data", out_data,         '0);
    chk("mid_rst_grp",  W'(grp_cnt),      '0);
    chk("mid_rst_err",  W'(err_underrun), '0);
    chk("mid_rst_rdy",  W'(acc_in_rdy),   '0);
    chk("mid_rst_rden", W'(fifo_rd_en),   '0);
    @(negedge clk_200M);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk_200M);
      chk("mid_no_stale", W'(out_vld), '0);
    end
    chk("mid_grp_zero", W'(grp_cnt),    '0);
    chk("mid_rdy_zero", W'(acc_in_rdy), '0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
